bp_be_fe_feedback_gen: RTL
==========================

Name: bp_be_fe_feedback_gen

Overview:
- Backend-side generator of frontend feedback: the redirect and attaboy messages consumed by the FE PC generator.
- Takes branch resolution events from the backend's branch unit and trap/resume events from the commit stage.
- Issues at most one redirect per cycle, with priority over all other feedback.
- Buffers correct-prediction training messages (attaboys) in a small FIFO drained with a valid/yumi handshake.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr_width_p and branch_metadata_fwd_width_p.
- attaboy_els_p, 2, attaboy FIFO depth (>=1).
- drop_cnt_width_p, 8, width of saturating attaboy-drop counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- resolve_v_i  in  1  branch/jump resolution valid, always accepted
- resolve_tgt_i  in  vaddr_width_p  resolved target of the control-flow instruction
- resolve_npc_i  in  vaddr_width_p  correct next fetch PC
- resolve_metadata_i  in  branch_metadata_fwd_width_p  metadata forwarded from FE with the instruction
- resolve_taken_i  in  1  resolved taken
- resolve_ntaken_i  in  1  resolved not-taken branch
- resolve_nonbr_i  in  1  instruction predicted as a branch by FE but is not a control-flow instruction
- resolve_mispredict_i  in  1  FE predicted next PC was wrong
- trap_v_i  in  1  commit-stage redirect (exception, interrupt, fence.i, CSR); always accepted
- trap_npc_i  in  vaddr_width_p  trap restart PC
- trap_resume_i  in  1  restart is a resume after a stall
- redirect_v_o  out  1  one-cycle redirect strobe
- redirect_pc_o  out  vaddr_width_p  target written into the BTB
- redirect_npc_o  out  vaddr_width_p  new fetch PC
- redirect_resume_o  out  1  resume flag
- redirect_br_v_o  out  1  redirect carries branch training
- redirect_br_metadata_fwd_o  out  branch_metadata_fwd_width_p  training metadata
- redirect_br_taken_o, redirect_br_ntaken_o, redirect_br_nonbr_o  out  1 each  training outcome
- attaboy_v_o  out  1  FIFO head valid
- attaboy_pc_o  out  vaddr_width_p  head target
- attaboy_br_metadata_fwd_o  out  branch_metadata_fwd_width_p  head metadata
- attaboy_taken_o, attaboy_ntaken_o  out  1 each  head outcome
- attaboy_yumi_i  in  1  FE consumed head; legal only when attaboy_v_o=1
- drop_count_o  out  drop_cnt_width_p  saturating count of dropped attaboys

Behaviour:
- Reset: all outputs 0, FIFO empty, drop_count_o=0. Reset asserted mid-operation discards pending redirect and FIFO contents on the next edge.
- Redirect register (latency 1): redirect outputs are registered and valid the cycle after the causing input. redirect_v_o is high for exactly one cycle per event; there is no backpressure.
- Redirect source priority in a cycle:
  1. trap_v_i: redirect_npc_o=trap_npc_i, redirect_pc_o=trap_npc_i, resume=trap_resume_i, br_v=0, outcome bits 0.
  2. Else resolve_v_i & (resolve_mispredict_i | resolve_nonbr_i): npc=resolve_npc_i, pc=resolve_tgt_i, br_v=1, metadata and taken/ntaken/nonbr copied, resume=0.
  3. Else no redirect.
- Attaboy enqueue:
  - Enqueue when resolve_v_i & ~resolve_mispredict_i & ~resolve_nonbr_i & ~trap_v_i & (resolve_taken_i | resolve_ntaken_i).
  - Entry = {tgt, metadata, taken, ntaken}. Visible at FIFO head no earlier than the next cycle.
- Trap flush: trap_v_i clears the FIFO on that edge. A same-cycle enqueue is suppressed; a same-cycle yumi is ignored.
- Redirect mask: attaboy_v_o is forced 0 while redirect_v_o=1, so the FE never sees both. The FIFO head holds and is presented the following cycle.
- Dequeue: attaboy_yumi_i pops the head on the edge. Back-to-back pops are allowed. Order is FIFO.
- Full:
  - Enqueue with FIFO full and no same-cycle yumi: drop the entry and increment drop_count_o, saturating at all-ones.
  - Enqueue with FIFO full and same-cycle yumi: succeeds, occupancy unchanged.
- Empty: attaboy_v_o=0. Yumi while empty is illegal (bench asserts).
- Pointers wrap modulo attaboy_els_p; occupancy counter width is clog2(attaboy_els_p+1).
- Input invariant: resolve_taken_i and resolve_ntaken_i are never both 1 (bench asserts).

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, drop_count_o=0.
- resolve_v_i with mispredict=1, taken=1, tgt=0x8000_0100, npc=0x8000_0100 -> next cycle redirect_v_o=1, br_v=1, taken=1, npc=0x8000_0100 for exactly 1 cycle; attaboy_v_o stays 0.
- Three correct taken resolves on consecutive cycles, tgt 0x100/0x200/0x300, yumi held 0, els=2 -> FIFO holds 0x100,0x200; drop_count_o=1. Then yumi for 2 cycles -> heads 0x100 then 0x200, then attaboy_v_o=0.
- trap_v_i (npc=0x4000, resume=1) together with a mispredict resolve, 2 attaboys queued -> redirect npc=0x4000, br_v=0, resume=1; FIFO empty the next cycle.
- Attaboy queued, then a mispredict redirect -> attaboy_v_o=0 in the redirect cycle, 1 in the following cycle with the same head contents.
- FIFO full, enqueue and yumi in the same cycle -> no drop, new entry at tail, occupancy stays 2.

Source files
------------

// File: rtl/bp_be_fe_feedback_gen.sv
// bp_be_fe_feedback_gen: backend redirect and attaboy feedback to the frontend PC generator
module bp_be_fe_feedback_gen #(
  parameter int vaddr_width_p = 39,
  parameter int branch_metadata_fwd_width_p = 32,
  parameter int attaboy_els_p = 2,
  parameter int drop_cnt_width_p = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   resolve_v_i,
  input  logic [vaddr_width_p-1:0]               resolve_tgt_i,
  input  logic [vaddr_width_p-1:0]               resolve_npc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] resolve_metadata_i,
  input  logic                                   resolve_taken_i,
  input  logic                                   resolve_ntaken_i,
  input  logic                                   resolve_nonbr_i,
  input  logic                                   resolve_mispredict_i,
  input  logic                                   trap_v_i,
  input  logic [vaddr_width_p-1:0]               trap_npc_i,
  input  logic                                   trap_resume_i,
  output logic                                   redirect_v_o,
  output logic [vaddr_width_p-1:0]               redirect_pc_o,
  output logic [vaddr_width_p-1:0]               redirect_npc_o,
  output logic                                   redirect_resume_o,
  output logic                                   redirect_br_v_o,
  output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
  output logic                                   redirect_br_taken_o,
  output logic                                   redirect_br_ntaken_o,
  output logic                                   redirect_br_nonbr_o,
  output logic                                   attaboy_v_o,
  output logic [vaddr_width_p-1:0]               attaboy_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
  output logic                                   attaboy_taken_o,
  output logic                                   attaboy_ntaken_o,
  input  logic                                   attaboy_yumi_i,
  output logic [drop_cnt_width_p-1:0]            drop_count_o
);
  localparam int pw_lp = attaboy_els_p > 1 ? $clog2(attaboy_els_p) : 1;
  localparam int cw_lp = $clog2(attaboy_els_p + 1);
  logic                                   r_redirect_v, r_resume, r_br_v, r_br_tk, r_br_nt, r_br_nb;
  logic [vaddr_width_p-1:0]               r_redirect_pc, r_redirect_npc;
  logic [branch_metadata_fwd_width_p-1:0] r_br_md;
  logic [vaddr_width_p-1:0]               r_tgt [attaboy_els_p];
  logic [branch_metadata_fwd_width_p-1:0] r_md [attaboy_els_p];
  logic                                   r_tk [attaboy_els_p];
  logic                                   r_nt [attaboy_els_p];
  logic [pw_lp-1:0]                       r_rptr, r_wptr;
  logic [cw_lp-1:0]                       r_cnt;
  logic [drop_cnt_width_p-1:0]            r_drop;
  logic w_redir, w_br_redir, w_enq_req, w_full, w_deq, w_enq, w_drop;
  function automatic logic [pw_lp-1:0] ptr_inc(input logic [pw_lp-1:0] p);
    return p == pw_lp'(attaboy_els_p - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_br_redir = resolve_v_i & (resolve_mispredict_i | resolve_nonbr_i);
  assign w_redir    = trap_v_i | w_br_redir;
  assign w_enq_req  = resolve_v_i & ~resolve_mispredict_i & ~resolve_nonbr_i & ~trap_v_i
                    & (resolve_taken_i | resolve_ntaken_i);
  assign w_full     = r_cnt == cw_lp'(attaboy_els_p);
  assign w_deq      = attaboy_yumi_i & attaboy_v_o & ~trap_v_i;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_enq      = w_enq_req & (~w_full | w_deq);
  assign w_drop     = w_enq_req & w_full & ~w_deq;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_redirect_v   <= 1'b0;
      r_redirect_pc  <= '0;
      r_redirect_npc <= '0;
      r_resume       <= 1'b0;
      r_br_v         <= 1'b0;
      r_br_md        <= '0;
      r_br_tk        <= 1'b0;
      r_br_nt        <= 1'b0;
      r_br_nb        <= 1'b0;
    end else begin
      r_redirect_v <= w_redir;
      if (w_redir) begin
        r_redirect_pc  <= trap_v_i ? trap_npc_i : resolve_tgt_i;
        r_redirect_npc <= trap_v_i ? trap_npc_i : resolve_npc_i;
        r_resume       <= trap_v_i & trap_resume_i;
        r_br_v         <= ~trap_v_i;
        r_br_md        <= trap_v_i ? '0 : resolve_metadata_i;
        r_br_tk        <= ~trap_v_i & resolve_taken_i;
        r_br_nt        <= ~trap_v_i & resolve_ntaken_i;
        r_br_nb        <= ~trap_v_i & resolve_nonbr_i;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_drop <= '0;
      for (int i = 0; i < attaboy_els_p; i++) begin
        r_tgt[i] <= '0;
        r_md[i]  <= '0;
        r_tk[i]  <= 1'b0;
        r_nt[i]  <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_tgt[r_wptr] <= resolve_tgt_i;
        r_md[r_wptr]  <= resolve_metadata_i;
        r_tk[r_wptr]  <= resolve_taken_i;
        r_nt[r_wptr]  <= resolve_ntaken_i;
      end
      r_drop <= (w_drop & ~&r_drop) ? r_drop + 1'b1 : r_drop;
      r_rptr <= trap_v_i ? '0 : w_deq ? ptr_inc(r_rptr) : r_rptr;
      r_wptr <= trap_v_i ? '0 : w_enq ? ptr_inc(r_wptr) : r_wptr;
      r_cnt  <= trap_v_i ? '0 : r_cnt + cw_lp'(w_enq) - cw_lp'(w_deq);
    end
  end
  assign redirect_v_o               = r_redirect_v;
  assign redirect_pc_o              = r_redirect_pc;
  assign redirect_npc_o             = r_redirect_npc;
  assign redirect_resume_o          = r_resume;
  assign redirect_br_v_o            = r_br_v;
  assign redirect_br_metadata_fwd_o = r_br_md;
  assign redirect_br_taken_o        = r_br_tk;
  assign redirect_br_ntaken_o       = r_br_nt;
  assign redirect_br_nonbr_o        = r_br_nb;
  // the head is hidden, not popped, during a redirect cycle
  assign attaboy_v_o                = (r_cnt != '0) & ~r_redirect_v;
  assign attaboy_pc_o               = r_tgt[r_rptr];
  assign attaboy_br_metadata_fwd_o  = r_md[r_rptr];
  assign attaboy_taken_o            = r_tk[r_rptr];
  assign attaboy_ntaken_o           = r_nt[r_rptr];
  assign drop_count_o               = r_drop;
endmodule
